// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve countdown, scoring, game-over detection and paddle motion.
// All outputs are registered; the serve button is edge-detected against its previous value.
module pong_game_ctrl #(
    parameter int MAX_SCORE   = 5,
    parameter int SERVE_DELAY = 60,
    parameter int BAR_LENGTH  = 180,
    parameter int BAR_SPEED   = 4,
    parameter int BAR_INIT    = 145,
    parameter int D_HEIGHT    = 470
) (
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic        in_ani_stb,
    input  logic        in_serve,
    input  logic        in_left_up,
    input  logic        in_left_down,
    input  logic        in_right_up,
    input  logic        in_right_down,
    input  logic        in_left_score,
    input  logic        in_right_score,
    output logic        out_start,
    output logic        out_animate,
    output logic        out_ball_reset,
    output logic [11:0] out_leftbar_top,
    output logic [11:0] out_rightbar_top,
    output logic [3:0]  out_left_points,
    output logic [3:0]  out_right_points,
    output logic [2:0]  out_state,
    output logic [1:0]  out_winner
);
    localparam int          CNT_W    = $clog2(SERVE_DELAY + 1);
    localparam logic [11:0] BAR_MAX  = 12'(D_HEIGHT - BAR_LENGTH);
    localparam logic [11:0] BAR_RST  = 12'(BAR_INIT);
    localparam logic [11:0] SPEED    = 12'(BAR_SPEED);
    localparam logic [3:0]  MAX_PTS  = 4'(MAX_SCORE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         lpts_q, lpts_d, rpts_q, rpts_d;
    logic [1:0]         winner_q, winner_d;
    logic [11:0]        lbar_q, lbar_d, rbar_q, rbar_d;
    logic               start_q, start_d;
    logic               animate_q, animate_d;
    logic               ball_reset_q, ball_reset_d;
    logic               serve_prev_q;
    logic               serve_edge;
    logic [3:0]         l_next, r_next;

    // Up xor down moves the bar; the down sum is one bit wider so it cannot wrap.
    function automatic logic [11:0] move_bar(input logic [11:0] top,
                                             input logic up, input logic down);
        logic [12:0] sum;
        sum      = {1'b0, top} + {1'b0, SPEED};
        move_bar = top;
        if (up && !down)
            move_bar = (top < SPEED) ? 12'd0 : top - SPEED;
        else if (down && !up)
            move_bar = (sum > {1'b0, BAR_MAX}) ? BAR_MAX : sum[11:0];
    endfunction

    always_comb begin
        serve_edge   = in_serve & ~serve_prev_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        lpts_d       = lpts_q;
        rpts_d       = rpts_q;
        winner_d     = winner_q;
        lbar_d       = lbar_q;
        rbar_d       = rbar_q;
        start_d      = 1'b0;
        ball_reset_d = 1'b0;
        l_next = (in_left_score  && lpts_q < MAX_PTS) ? lpts_q + 4'd1 : lpts_q;
        r_next = (in_right_score && rpts_q < MAX_PTS) ? rpts_q + 4'd1 : rpts_q;

        if (in_ani_stb && state_q != OVER) begin
            lbar_d = move_bar(lbar_q, in_left_up, in_left_down);
            rbar_d = move_bar(rbar_q, in_right_up, in_right_down);
        end

        case (state_q)
            IDLE: begin
                if (serve_edge) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end
            end
            SERVE: begin
                if (in_ani_stb) begin
                    if (cnt_q == CNT_W'(SERVE_DELAY - 1)) begin
                        state_d = PLAY;
                        cnt_d   = '0;
                        start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PLAY: begin
                lpts_d = l_next;
                rpts_d = r_next;
                if (l_next == MAX_PTS || r_next == MAX_PTS) begin
                    state_d  = OVER;
                    winner_d = {r_next == MAX_PTS, l_next == MAX_PTS};
                end else if (in_left_score || in_right_score) begin
                    state_d = POINT;
                end
            end
            POINT: begin
                if (serve_edge) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end
            end
            OVER: begin
                if (serve_edge) begin
                    state_d      = SERVE;
                    cnt_d        = '0;
                    lpts_d       = '0;
                    rpts_d       = '0;
                    winner_d     = '0;
                    lbar_d       = BAR_RST;
                    rbar_d       = BAR_RST;
                    ball_reset_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        animate_d = (state_d == PLAY);
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lpts_q       <= '0;
            rpts_q       <= '0;
            winner_q     <= '0;
            lbar_q       <= BAR_RST;
            rbar_q       <= BAR_RST;
            start_q      <= 1'b0;
            animate_q    <= 1'b0;
            ball_reset_q <= 1'b1;
            serve_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lpts_q       <= lpts_d;
            rpts_q       <= rpts_d;
            winner_q     <= winner_d;
            lbar_q       <= lbar_d;
            rbar_q       <= rbar_d;
            start_q      <= start_d;
            animate_q    <= animate_d;
            ball_reset_q <= ball_reset_d;
            serve_prev_q <= in_serve;
        end
    end

    assign out_start        = start_q;
    assign out_animate      = animate_q;
    assign out_ball_reset   = ball_reset_q;
    assign out_leftbar_top  = lbar_q;
    assign out_rightbar_top = rbar_q;
    assign out_left_points  = lpts_q;
    assign out_right_points = rpts_q;
    assign out_state        = state_q;
    assign out_winner       = winner_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve countdown, scoring, game over, paddles, reset cases.
module tb_pong_game_ctrl;
    logic        clk = 1'b0;
    logic        rst, ani, serve, lu, ld, ru, rd, ls, rs;
    logic        start, animate, ball_reset;
    logic [11:0] lbar, rbar;
    logic [3:0]  lpts, rpts;
    logic [2:0]  state;
    logic [1:0]  winner;
    int          checks = 0;
    int          failures = 0;

    pong_game_ctrl dut (
        .in_clock(clk), .in_reset(rst), .in_ani_stb(ani), .in_serve(serve),
        .in_left_up(lu), .in_left_down(ld), .in_right_up(ru), .in_right_down(rd),
        .in_left_score(ls), .in_right_score(rs),
        .out_start(start), .out_animate(animate), .out_ball_reset(ball_reset),
        .out_leftbar_top(lbar), .out_rightbar_top(rbar),
        .out_left_points(lpts), .out_right_points(rpts),
        .out_state(state), .out_winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stb;
        logic [3:0] btn;      // {lu, ld, ru, rd}
        int         reps;
        int         exp_lbar;
        int         exp_rbar;
    } pad_vec_t;

    pad_vec_t pad_tab[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic strobe();
        ani = 1'b1; tick(); ani = 1'b0; tick();
    endtask

    task automatic serve_press();
        serve = 1'b1; tick(); serve = 1'b0;
    endtask

    task automatic serve_to_play(input string tag);
        serve_press();
        check({tag, "_serve_state"}, state, 1);
        tick();
        for (int i = 0; i < 59; i++) strobe();
        check({tag, "_wait_state"}, state, 1);
        ani = 1'b1; tick(); ani = 1'b0;
        check({tag, "_play_state"}, state, 2);
        check({tag, "_start"}, start, 1);
        check({tag, "_animate"}, animate, 1);
        tick();
        check({tag, "_start_gone"}, start, 0);
    endtask

    task automatic score(input logic l, input logic r);
        ls = l; rs = r; tick(); ls = 1'b0; rs = 1'b0;
    endtask

    initial begin
        pad_tab[0]  = '{1'b1, 4'b1000, 40, 0,   145};
        pad_tab[1]  = '{1'b1, 4'b1000, 5,  0,   145};
        pad_tab[2]  = '{1'b1, 4'b0100, 72, 288, 145};
        pad_tab[3]  = '{1'b1, 4'b0100, 1,  290, 145};
        pad_tab[4]  = '{1'b1, 4'b0100, 3,  290, 145};
        pad_tab[5]  = '{1'b1, 4'b1100, 5,  290, 145};
        pad_tab[6]  = '{1'b1, 4'b0001, 10, 290, 185};
        pad_tab[7]  = '{1'b1, 4'b0010, 10, 290, 145};
        pad_tab[8]  = '{1'b1, 4'b0011, 3,  290, 145};
        pad_tab[9]  = '{1'b1, 4'b0010, 1,  290, 141};
        pad_tab[10] = '{1'b0, 4'b0001, 3,  290, 141};

        rst = 1'b1; ani = 0; serve = 0; lu = 0; ld = 0; ru = 0; rd = 0; ls = 0; rs = 0;
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_lpts", lpts, 0);
        check("rst_rpts", rpts, 0);
        check("rst_winner", winner, 0);
        check("rst_lbar", lbar, 145);
        check("rst_rbar", rbar, 145);
        check("rst_start", start, 0);
        check("rst_animate", animate, 0);
        rst = 1'b0;
        check("rst_ball_reset_first", ball_reset, 1);
        tick();
        check("rst_ball_reset_after", ball_reset, 0);

        serve_to_play("first");
        check("play_animate_hold", animate, 1);
        serve_press();
        check("serve_in_play_ignored", state, 2);
        tick();

        for (int v = 0; v < 11; v++) begin
            {lu, ld, ru, rd} = pad_tab[v].btn;
            for (int k = 0; k < pad_tab[v].reps; k++) begin
                ani = pad_tab[v].stb; tick(); ani = 1'b0; tick();
            end
            {lu, ld, ru, rd} = 4'b0000;
            check($sformatf("pad%0d_lbar", v), lbar, pad_tab[v].exp_lbar);
            check($sformatf("pad%0d_rbar", v), rbar, pad_tab[v].exp_rbar);
        end

        score(1'b0, 1'b1);
        check("rpoint_rpts", rpts, 1);
        check("rpoint_state", state, 3);
        check("rpoint_animate", animate, 0);
        score(1'b1, 1'b0);
        check("point_ignored_lpts", lpts, 0);
        check("point_ignored_state", state, 3);
        tick();
        serve_to_play("replay");

        for (int i = 1; i <= 5; i++) begin
            score(1'b1, 1'b0);
            check($sformatf("lscore%0d_pts", i), lpts, i);
            if (i < 5) begin
                check($sformatf("lscore%0d_state", i), state, 3);
                tick();
                serve_to_play("lround");
            end
        end
        check("over_state", state, 4);
        check("over_winner", winner, 1);
        check("over_rpts", rpts, 1);
        check("over_animate", animate, 0);
        score(1'b1, 1'b1);
        check("over_score_ignored", lpts, 5);
        lu = 1'b1; strobe(); lu = 1'b0;
        check("over_bar_frozen", lbar, 290);
        serve_press();
        check("newgame_state", state, 1);
        check("newgame_lpts", lpts, 0);
        check("newgame_rpts", rpts, 0);
        check("newgame_winner", winner, 0);
        check("newgame_ball_reset", ball_reset, 1);
        check("newgame_lbar", lbar, 145);
        check("newgame_rbar", rbar, 141 == 141 ? 145 : 0);
        tick();
        check("newgame_ball_reset_end", ball_reset, 0);
        for (int i = 0; i < 60; i++) strobe();
        check("newgame_play", state, 2);

        for (int i = 0; i < 8; i++) begin
            score(i[0], ~i[0]);
            tick();
            serve_to_play("tie");
        end
        check("tie_lpts", lpts, 4);
        check("tie_rpts", rpts, 4);
        score(1'b1, 1'b1);
        check("both_lpts", lpts, 5);
        check("both_rpts", rpts, 5);
        check("both_winner", winner, 3);
        check("both_state", state, 4);
        tick();

        serve_press();
        tick();
        for (int i = 0; i < 30; i++) strobe();
        check("midserve_state", state, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_state", state, 0);
        check("abort_start", start, 0);
        tick();
        check("abort_no_start", start, 0);
        serve_to_play("after_abort");

        serve = 1'b1; rst = 1'b1; tick(); tick(); rst = 1'b0;
        tick(); tick();
        check("held_serve_idle", state, 0);
        serve = 1'b0; tick();
        serve = 1'b1; tick(); serve = 1'b0;
        check("repress_serve", state, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameters: MAX_SCORE=5 (points to win); SERVE_DELAY=60 (ani strobes before serve); BAR_LENGTH=180; BAR_SPEED=4 (px per strobe); BAR_INIT=145 (initial bar top); D_HEIGHT=470.
REQ-002 in_clock  in  1  base clock; sole clock.
REQ-003 in_reset  in  1  synchronous, active-high reset.
REQ-004 in_ani_stb  in  1  one-cycle frame strobe.
REQ-005 in_serve  in  1  serve/new-game button, level.
REQ-006 in_left_up, in_left_down, in_right_up, in_right_down  in  1 each  paddle buttons, level.
REQ-007 in_left_score, in_right_score  in  1 each  one-cycle point pulses from the ball block.
REQ-008 out_start  out  1  one-cycle pulse that releases the ball.
REQ-009 out_animate  out  1  ball animation enable.
REQ-010 out_ball_reset  out  1  one-cycle pulse that recentres the ball.
REQ-011 out_leftbar_top, out_rightbar_top  out  12 each  paddle top edges.
REQ-012 out_left_points, out_right_points  out  4 each  scores.
REQ-013 out_state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-014 out_winner  out  2  bit0 = left won, bit1 = right won.

Function
REQ-015 Serve edge: fires in the cycle in_serve is 1 and its previous-cycle registered value is 0; all "serve edge" below means this.
REQ-016 IDLE: on serve edge -> SERVE; serve counter cleared.
REQ-017 SERVE: counter increments on each in_ani_stb; on the strobe that brings it to SERVE_DELAY -> PLAY, counter cleared.
REQ-018 out_start is 1 exactly in the first cycle with state PLAY; 0 otherwise.
REQ-019 out_animate = 1 iff state is PLAY (registered with state).
REQ-020 PLAY: in_left_score increments out_left_points; in_right_score increments out_right_points; both in the same cycle increment both.
REQ-021 PLAY, after the increment: if either score equals MAX_SCORE -> OVER, out_winner set from which score(s) equal MAX_SCORE (both bits may be set); else any score pulse -> POINT.
REQ-022 Score pulses outside PLAY are ignored; scores never exceed MAX_SCORE.
REQ-023 POINT: serve edge -> SERVE; scores held.
REQ-024 OVER: serve edge -> SERVE; in the same cycle scores cleared, out_winner cleared, bar tops set to BAR_INIT, out_ball_reset pulsed for one cycle.
REQ-025 out_ball_reset is 0 in all other cycles except the one after reset (REQ-029).
REQ-026 Paddles update only on in_ani_stb and not in OVER: up xor down moves the bar; both or neither hold it.
REQ-027 Up: top <= (top < BAR_SPEED) ? 0 : top - BAR_SPEED. Down: top <= min(top + BAR_SPEED, D_HEIGHT - BAR_LENGTH); 12-bit, no wrap.
REQ-028 Serve edge in PLAY or SERVE has no effect.

Reset
REQ-029 In_reset overrides all other logic in that cycle: state IDLE, scores 0, out_winner 0, serve counter 0, bar tops BAR_INIT, out_start 0, out_animate 0, serve edge register 1 (a button held through reset does not fire), out_ball_reset 1 in the first cycle after reset, then 0.
REQ-030 Reset asserted mid-PLAY or mid-SERVE aborts the round and the serve count with no out_start pulse.

Verification
REQ-031 Reset, serve edge, 60 strobes -> state SERVE until the 60th strobe; next cycle state=2, out_start=1 for 1 cycle, out_animate=1.
REQ-032 In PLAY, pulse in_right_score -> out_right_points=1, state=3, out_animate=0; serve edge + 60 strobes -> PLAY again.
REQ-033 Left scores 5 points -> state=4, out_winner=01; serve edge -> points 0/0, out_ball_reset 1 cycle, bars=145, state=1.
REQ-034 Hold in_left_up for 40 strobes -> out_leftbar_top 145 -> 0, then held at 0; hold in_left_down -> saturates at 290; up+down together -> no change.
REQ-035 Both score pulses in the same cycle at 4-4 -> points 5/5, out_winner=11, state=4.
REQ-036 in_serve held high across reset release -> stays IDLE; release and press again -> SERVE.
